// File: rtl/axi_pkg.sv
// Shared AXI crossbar types: response codes and read/write FSM encodings.
// Error states are only reached when AXI_XBAR_DECERR_EN is defined.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ACTIVE,
    W_RESP,
    W_ERR,
    W_ERR_B
  } w_state_t;

endpackage

// File: rtl/axi_addr_decode.sv
// Address to one-hot slave select against a packed base/mask map.
// Overlapping ranges resolve to the lowest slave index.
module axi_addr_decode #(
  parameter int                      N_SLV    = 2,
  parameter int                      ADDR_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_SLV-1:0]  sel_o,
  output logic              hit_o
);

  // Scan high to low so the lowest matching index is the last to write.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W])
          == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_xbar_1ton.sv
// 1-to-N AXI interconnect with independent read and write routing FSMs.
// Define AXI_XBAR_DECERR_EN to answer unmapped addresses with DECERR.
module axi_xbar_1ton
  import axi_pkg::*;
#(
  parameter int                      N_SLV    = 2,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m_arvalid_i,
  output logic                    m_arready_o,
  input  logic [ADDR_W-1:0]       m_araddr_i,
  output logic                    m_rvalid_o,
  input  logic                    m_rready_i,
  output logic                    m_rlast_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic [1:0]              m_rresp_o,
  input  logic                    m_awvalid_i,
  output logic                    m_awready_o,
  input  logic [ADDR_W-1:0]       m_awaddr_i,
  input  logic                    m_wvalid_i,
  output logic                    m_wready_o,
  input  logic                    m_wlast_i,
  input  logic [DATA_W-1:0]       m_wdata_i,
  output logic                    m_bvalid_o,
  input  logic                    m_bready_i,
  output logic [1:0]              m_bresp_o,
  output logic [N_SLV-1:0]        s_arvalid_o,
  input  logic [N_SLV-1:0]        s_arready_i,
  output logic [N_SLV*ADDR_W-1:0] s_araddr_o,
  input  logic [N_SLV-1:0]        s_rvalid_i,
  output logic [N_SLV-1:0]        s_rready_o,
  input  logic [N_SLV-1:0]        s_rlast_i,
  input  logic [N_SLV*DATA_W-1:0] s_rdata_i,
  input  logic [N_SLV*2-1:0]      s_rresp_i,
  output logic [N_SLV-1:0]        s_awvalid_o,
  input  logic [N_SLV-1:0]        s_awready_i,
  output logic [N_SLV*ADDR_W-1:0] s_awaddr_o,
  output logic [N_SLV-1:0]        s_wvalid_o,
  input  logic [N_SLV-1:0]        s_wready_i,
  output logic [N_SLV-1:0]        s_wlast_o,
  output logic [N_SLV*DATA_W-1:0] s_wdata_o,
  input  logic [N_SLV-1:0]        s_bvalid_i,
  output logic [N_SLV-1:0]        s_bready_o,
  input  logic [N_SLV*2-1:0]      s_bresp_i
);

  r_state_t          r_state, r_state_n;
  w_state_t          w_state, w_state_n;
  logic [N_SLV-1:0]  r_sel, w_sel;
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
  logic              ar_rdy_q, aw_rdy_q;
  logic              aw_done, aw_done_n;
  logic              w_done, w_done_n;
  logic              ar_hs, aw_hs;
  logic [N_SLV-1:0]  ar_dec, aw_dec;
  logic              ar_hit, aw_hit;
  logic [N_SLV-1:0]  ar_sel_n, aw_sel_n;
  logic              ar_err, aw_err;

  axi_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_ar_dec (
    .addr_i (m_araddr_i),
    .sel_o  (ar_dec),
    .hit_o  (ar_hit)
  );

  axi_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_aw_dec (
    .addr_i (m_awaddr_i),
    .sel_o  (aw_dec),
    .hit_o  (aw_hit)
  );

`ifdef AXI_XBAR_DECERR_EN
  assign ar_sel_n = ar_dec;
  assign aw_sel_n = aw_dec;
  assign ar_err   = ~ar_hit;
  assign aw_err   = ~aw_hit;
`else
  // Unmapped traffic falls through to the last slave.
  localparam logic [N_SLV-1:0] DFLT = N_SLV'(1) << (N_SLV - 1);
  assign ar_sel_n = ar_hit ? ar_dec : DFLT;
  assign aw_sel_n = aw_hit ? aw_dec : DFLT;
  assign ar_err   = 1'b0;
  assign aw_err   = 1'b0;
`endif

  assign m_arready_o = ar_rdy_q;
  assign m_awready_o = aw_rdy_q;
  assign ar_hs       = m_arvalid_i & ar_rdy_q;
  assign aw_hs       = m_awvalid_i & aw_rdy_q;
  assign s_araddr_o  = {N_SLV{ar_addr_q}};
  assign s_awaddr_o  = {N_SLV{aw_addr_q}};

  always_comb begin
    r_state_n   = r_state;
    s_arvalid_o = '0;
    s_rready_o  = '0;
    m_rvalid_o  = 1'b0;
    m_rlast_o   = 1'b0;
    m_rdata_o   = '0;
    m_rresp_o   = RESP_OKAY;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) r_state_n = ar_err ? R_ERR : R_ADDR;
      end
      R_ADDR: begin
        s_arvalid_o = r_sel;
        if (|(s_arready_i & r_sel)) r_state_n = R_DATA;
      end
      R_DATA: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (r_sel[i]) begin
            m_rvalid_o = s_rvalid_i[i];
            m_rlast_o  = s_rlast_i[i];
            m_rdata_o  = s_rdata_i[i*DATA_W +: DATA_W];
            m_rresp_o  = s_rresp_i[i*2 +: 2];
          end
        end
        s_rready_o = r_sel & {N_SLV{m_rready_i}};
        if (m_rvalid_o && m_rready_i && m_rlast_o) r_state_n = R_IDLE;
      end
`ifdef AXI_XBAR_DECERR_EN
      R_ERR: begin
        m_rvalid_o = 1'b1;
        m_rlast_o  = 1'b1;
        m_rresp_o  = RESP_DECERR;
        if (m_rready_i) r_state_n = R_IDLE;
      end
`endif
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= R_IDLE;
      ar_rdy_q  <= 1'b0;
      r_sel     <= '0;
      ar_addr_q <= '0;
    end else begin
      r_state  <= r_state_n;
      ar_rdy_q <= (r_state_n == R_IDLE);
      if (ar_hs) begin
        r_sel     <= ar_sel_n;
        ar_addr_q <= m_araddr_i;
      end
    end
  end

  // W data may reach the slave before its AW; the two flags track each side.
  always_comb begin
    w_state_n   = w_state;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    s_awvalid_o = '0;
    s_wvalid_o  = '0;
    s_wlast_o   = '0;
    s_wdata_o   = '0;
    s_bready_o  = '0;
    m_wready_o  = 1'b0;
    m_bvalid_o  = 1'b0;
    m_bresp_o   = RESP_OKAY;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_n = aw_err ? W_ERR : W_ACTIVE;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      W_ACTIVE: begin
        s_awvalid_o = w_sel & {N_SLV{~aw_done}};
        s_wvalid_o  = w_sel & {N_SLV{m_wvalid_i & ~w_done}};
        s_wlast_o   = {N_SLV{m_wlast_i}};
        s_wdata_o   = {N_SLV{m_wdata_i}};
        m_wready_o  = ~w_done & |(s_wready_i & w_sel);
        if (|(s_awready_i & s_awvalid_o)) aw_done_n = 1'b1;
        if (m_wvalid_i && m_wready_o && m_wlast_i) w_done_n = 1'b1;
        if (aw_done_n && w_done_n) w_state_n = W_RESP;
      end
      W_RESP: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (w_sel[i]) begin
            m_bvalid_o = s_bvalid_i[i];
            m_bresp_o  = s_bresp_i[i*2 +: 2];
          end
        end
        s_bready_o = w_sel & {N_SLV{m_bready_i}};
        if (m_bvalid_o && m_bready_i) w_state_n = W_IDLE;
      end
`ifdef AXI_XBAR_DECERR_EN
      W_ERR: begin
        m_wready_o = 1'b1;
        if (m_wvalid_i && m_wlast_i) w_state_n = W_ERR_B;
      end
      W_ERR_B: begin
        m_bvalid_o = 1'b1;
        m_bresp_o  = RESP_DECERR;
        if (m_bready_i) w_state_n = W_IDLE;
      end
`endif
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      aw_rdy_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      w_sel     <= '0;
      aw_addr_q <= '0;
    end else begin
      w_state  <= w_state_n;
      aw_rdy_q <= (w_state_n == W_IDLE);
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      if (aw_hs) begin
        w_sel     <= aw_sel_n;
        aw_addr_q <= m_awaddr_i;
      end
    end
  end

endmodule

// File: doc/axi_xbar_1ton.md
# axi_xbar_1ton

Parametrised 1-master-to-N-slave AXI interconnect: sits between the CPU/DMA master port and the SoC peripherals and memory. It decodes each AR/AW address against a per-slave base/mask map, latches the selected slave, and routes that transaction's channels until it completes. Read and write paths are independent FSMs and may be in flight concurrently. An optional internal error slave answers unmapped addresses.

## Interface
- N_SLV, 2, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLV_BASE, 0, N_SLV×ADDR_W packed base addresses; slave i in [i*ADDR_W +: ADDR_W]
- SLV_MASK, 0, N_SLV×ADDR_W packed masks; slave i hit when (addr & mask_i) == base_i

Ports (s_* buses are flattened, slave i at [i*W +: W]):
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m_arvalid_i / m_arready_o / m_araddr_i  in/out/in  1/1/ADDR_W  master AR
- m_rvalid_o / m_rready_i / m_rlast_o / m_rdata_o / m_rresp_o  out/in/out/out/out  1/1/1/DATA_W/2  master R
- m_awvalid_i / m_awready_o / m_awaddr_i  in/out/in  1/1/ADDR_W  master AW
- m_wvalid_i / m_wready_o / m_wlast_i / m_wdata_i  in/out/in/in  1/1/1/DATA_W  master W
- m_bvalid_o / m_bready_i / m_bresp_o  out/in/out  1/1/2  master B
- s_arvalid_o / s_arready_i / s_araddr_o  out/in/out  N_SLV/N_SLV/N_SLV*ADDR_W
- s_rvalid_i / s_rready_o / s_rlast_i / s_rdata_i / s_rresp_i  in/out/in/in/in  N_SLV/N_SLV/N_SLV/N_SLV*DATA_W/N_SLV*2
- s_awvalid_o / s_awready_i / s_awaddr_o  out/in/out  N_SLV/N_SLV/N_SLV*ADDR_W
- s_wvalid_o / s_wready_i / s_wlast_o / s_wdata_o  out/in/out/out  N_SLV/N_SLV/N_SLV/N_SLV*DATA_W
- s_bvalid_i / s_bready_o / s_bresp_i  in/out/in  N_SLV/N_SLV/N_SLV*2

## Operation
- Decode: lowest-index hit wins on overlapping ranges; no hit = unmapped.
- Read FSM R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: m_arready_o=1; on AR handshake latch address and one-hot select, go R_ADDR.
  - R_ADDR: s_arvalid_o[sel]=1 until s_arready_i[sel]; then R_DATA.
  - R_DATA: m_rvalid/rlast/rdata/rresp ← slave sel; s_rready_o[sel] ← m_rready_i. Handshake with rlast → R_IDLE.
- Write FSM W_IDLE → W_ACTIVE → W_RESP → W_IDLE.
  - W_IDLE: m_awready_o=1; AW handshake latches select.
  - W_ACTIVE: s_awvalid_o[sel] until accepted (flag aw_done). W routed to sel from entry (W may precede AW at slave); handshake with wlast sets w_done, then m_wready_o=0. Both flags set → W_RESP.
  - W_RESP: B routed from sel; bvalid&bready → W_IDLE.
- Non-selected slaves: all valid/ready outputs 0. s_*addr_o and s_wdata_o/s_wlast_o broadcast to all slaves (only the valid is qualified).
- Read and write to the same slave concurrently are permitted.

## Timing
- Reset: all FSMs to IDLE; every valid/ready/last output 0, addresses/data/resp 0. m_arready_o and m_awready_o are registered and rise the first edge after rst_i deasserts.
- AR accepted at edge T → s_arvalid_o[sel] high from T+1. R path combinational (zero added latency). Last R handshake at T → m_arready_o high at T+1.
- AW same: s_awvalid_o from T+1; W beats pass combinationally from T+1; B handshake at T → m_awready_o at T+1.
- Reset mid-transaction: abandon immediately; no response is generated.
- Slave asserting rvalid/bvalid while not selected: ignored (ready stays 0).

## Configuration
- AXI_XBAR_DECERR_EN defined: unmapped reads go R_ERR (m_rvalid_o=1, rdata 0, rresp 2'b11, rlast 1, until m_rready_i); unmapped writes go W_ERR (m_wready_o=1 sinking beats to wlast) then B with bresp 2'b11. No slave valids assert.
- Undefined: unmapped addresses route to slave N_SLV-1 (default slave); no error states synthesised.

## Structure
- Package axi_pkg: RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11, read/write state encodings.
- Sub-module axi_addr_decode: combinational addr → one-hot select + hit; instantiated once for AR, once for AW.

## Test plan
- N_SLV=2, slave0 0x0000_0000/0xF000_0000, slave1 0x1000_0000/0xF000_0000: read 0x1000_0004, slave1 returns 0xDEAD_BEEF rlast → master sees it, resp 00, s_arvalid_o[0] never 1.
- 4-beat write to 0x0000_0010, slave0 wready toggling, AW accepted after W beat 2 → all 4 beats delivered in order, single B OKAY.
- Concurrent read of slave0 and write to slave1 → both complete, no cross-routing.
- With AXI_XBAR_DECERR_EN, read 0x2000_0000 → one beat rresp 11, rlast 1, rdata 0; 3-beat write → B resp 11.
- Without macro, read 0x2000_0000 → s_arvalid_o[1] asserted.
- rst_i pulsed during R_DATA → all outputs 0 immediately; m_arready_o returns 1 edge after release.
